// File: rtl/avmm_page_burst_splitter.sv
// Avalon-MM burst splitter: cuts bursts at page boundaries, merges write responses.
// Optional split statistics counter: define AVMM_PAGE_SPLIT_STATS_EN.
module avmm_page_burst_splitter #(
    parameter int ADDR_WIDTH        = 48,
    parameter int DATA_WIDTH        = 512,
    parameter int BURST_CNT_WIDTH   = 7,
    parameter int USER_WIDTH        = 8,
    parameter int PAGE_LINES_LOG2   = 6,
    parameter int WR_RSP_FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      s_address,
    input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
    input  logic [USER_WIDTH-1:0]      s_user,
    input  logic                       s_read,
    input  logic                       s_write,
    input  logic [DATA_WIDTH-1:0]      s_writedata,
    input  logic [DATA_WIDTH/8-1:0]    s_byteenable,
    output logic                       s_waitrequest,
    output logic [DATA_WIDTH-1:0]      s_readdata,
    output logic                       s_readdatavalid,
    output logic                       s_writeresponsevalid,
    output logic [ADDR_WIDTH-1:0]      m_address,
    output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
    output logic [USER_WIDTH-1:0]      m_user,
    output logic                       m_read,
    output logic                       m_write,
    output logic [DATA_WIDTH-1:0]      m_writedata,
    output logic [DATA_WIDTH/8-1:0]    m_byteenable,
    input  logic                       m_waitrequest,
    input  logic [DATA_WIDTH-1:0]      m_readdata,
    input  logic                       m_readdatavalid,
    input  logic                       m_writeresponsevalid,
    output logic [31:0]                split_count
);

    localparam int BW = BURST_CNT_WIDTH;
    localparam int CW = ((BW > PAGE_LINES_LOG2) ? BW : PAGE_LINES_LOG2) + 1;
    localparam int FA = (WR_RSP_FIFO_DEPTH > 1) ? $clog2(WR_RSP_FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] PAGE = CW'(1) << PAGE_LINES_LOG2;

    typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_SPLIT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          rem_q, rem_d;
    logic [CW-1:0]          sub_left_q, sub_left_d;
    logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
    logic                   rst_done_q;

    logic                   m_read_q, m_read_d;
    logic                   m_write_q, m_write_d;
    logic [ADDR_WIDTH-1:0]  m_address_q, m_address_d;
    logic [BW-1:0]          m_burstcount_q, m_burstcount_d;
    logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
    logic [DATA_WIDTH-1:0]  m_writedata_q, m_writedata_d;
    logic [DATA_WIDTH/8-1:0] m_byteenable_q, m_byteenable_d;

    logic [BW-1:0]          fifo_mem [WR_RSP_FIFO_DEPTH];
    logic [FA-1:0]          wr_ptr_q, wr_ptr_d;
    logic [FA-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FA:0]            fifo_cnt_q, fifo_cnt_d;
    logic [BW-1:0]          rsp_cnt_q, rsp_cnt_d;
    logic                   s_wrv_q, s_wrv_d;

    logic [CW-1:0] s_len, s_room, s_first, s_rest, s_nsub, rem_take;
    logic          is_split, out_held, out_free, fifo_full, fifo_empty;
    logic          accept_rd, accept_wr_first, accept_wr_beat;
    logic          push, pop;
    logic [BW-1:0] rsp_next;

    // Page geometry of the incoming command and of the pending remainder
    always_comb begin
        s_len    = CW'(s_burstcount);
        s_room   = PAGE - CW'(s_address[PAGE_LINES_LOG2-1:0]);
        s_first  = (s_len < s_room) ? s_len : s_room;
        s_rest   = s_len - s_first;
        s_nsub   = CW'(1) + ((s_rest + PAGE - CW'(1)) >> PAGE_LINES_LOG2);
        is_split = s_len > s_room;
        rem_take = (rem_q < PAGE) ? rem_q : PAGE;
    end

    assign out_held   = (m_read_q | m_write_q) & m_waitrequest;
    assign out_free   = ~out_held;
    assign fifo_full  = fifo_cnt_q == (FA+1)'(WR_RSP_FIFO_DEPTH);
    assign fifo_empty = fifo_cnt_q == '0;

    assign accept_rd = rst_done_q & (state_q == IDLE) & out_free & s_read;
    assign accept_wr_first = rst_done_q & (state_q == IDLE) & out_free
                           & s_write & ~s_read & ~fifo_full;
    assign accept_wr_beat = (state_q == WR_SPLIT) & out_free & s_write;

    assign s_waitrequest = ~rst_done_q | out_held | (state_q == RD_SPLIT)
                         | ((state_q == IDLE) & s_write & ~s_read & fifo_full);

    assign s_readdata           = m_readdata;
    assign s_readdatavalid      = m_readdatavalid;
    assign s_writeresponsevalid = s_wrv_q;
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign m_address    = m_address_q;
    assign m_burstcount = m_burstcount_q;
    assign m_user       = m_user_q;
    assign m_writedata  = m_writedata_q;
    assign m_byteenable = m_byteenable_q;

    // Splitter FSM: accept commands/beats and load the downstream output register
    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        sub_left_d     = sub_left_q;
        next_addr_d    = next_addr_q;
        m_read_d       = m_read_q;
        m_write_d      = m_write_q;
        m_address_d    = m_address_q;
        m_burstcount_d = m_burstcount_q;
        m_user_d       = m_user_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;
        if (out_free) begin
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    m_read_d       = 1'b1;
                    m_address_d    = s_address;
                    m_burstcount_d = BW'(s_first);
                    m_user_d       = s_user;
                    rem_d          = s_rest;
                    next_addr_d    = s_address + ADDR_WIDTH'(s_first);
                    state_d        = is_split ? RD_SPLIT : IDLE;
                end else if (accept_wr_first) begin
                    m_write_d      = 1'b1;
                    m_address_d    = s_address;
                    m_burstcount_d = BW'(s_first);
                    m_user_d       = s_user;
                    m_writedata_d  = s_writedata;
                    m_byteenable_d = s_byteenable;
                    rem_d          = s_len - CW'(1);
                    sub_left_d     = s_first - CW'(1);
                    next_addr_d    = s_address + ADDR_WIDTH'(s_first);
                    state_d        = (s_len > CW'(1)) ? WR_SPLIT : IDLE;
                end
            end
            RD_SPLIT: begin
                if (out_free) begin
                    m_read_d       = 1'b1;
                    m_address_d    = next_addr_q;
                    m_burstcount_d = BW'(rem_take);
                    rem_d          = rem_q - rem_take;
                    next_addr_d    = next_addr_q + ADDR_WIDTH'(rem_take);
                    if (rem_q == rem_take) state_d = IDLE;
                end
            end
            WR_SPLIT: begin
                if (accept_wr_beat) begin
                    m_write_d      = 1'b1;
                    m_writedata_d  = s_writedata;
                    m_byteenable_d = s_byteenable;
                    rem_d          = rem_q - CW'(1);
                    if (sub_left_q == '0) begin
                        m_address_d    = next_addr_q;
                        m_burstcount_d = BW'(rem_take);
                        sub_left_d     = rem_take - CW'(1);
                        next_addr_d    = next_addr_q + ADDR_WIDTH'(rem_take);
                    end else begin
                        sub_left_d = sub_left_q - CW'(1);
                    end
                    if (rem_q == CW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write response merge: count downstream responses against the FIFO head
    always_comb begin
        push       = accept_wr_first;
        rsp_next   = rsp_cnt_q + BW'(1);
        pop        = m_writeresponsevalid & ~fifo_empty
                   & (rsp_next == fifo_mem[rd_ptr_q]);
        s_wrv_d    = pop;
        rsp_cnt_d  = rsp_cnt_q;
        if (m_writeresponsevalid) rsp_cnt_d = pop ? '0 : rsp_next;
        wr_ptr_d   = wr_ptr_q + FA'(push);
        rd_ptr_d   = rd_ptr_q + FA'(pop);
        fifo_cnt_d = fifo_cnt_q + (FA+1)'(push) - (FA+1)'(pop);
    end

    // State, output and FIFO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            sub_left_q     <= '0;
            next_addr_q    <= '0;
            rst_done_q     <= 1'b0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_burstcount_q <= '0;
            m_user_q       <= '0;
            m_writedata_q  <= '0;
            m_byteenable_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            rsp_cnt_q      <= '0;
            s_wrv_q        <= 1'b0;
            for (int i = 0; i < WR_RSP_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            sub_left_q     <= sub_left_d;
            next_addr_q    <= next_addr_d;
            rst_done_q     <= 1'b1;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_burstcount_q <= m_burstcount_d;
            m_user_q       <= m_user_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            s_wrv_q        <= s_wrv_d;
            if (push) fifo_mem[wr_ptr_q] <= BW'(s_nsub);
        end
    end

`ifdef AVMM_PAGE_SPLIT_STATS_EN
    logic [31:0] split_cnt_q, split_cnt_d;

    // Saturating count of bursts that needed more than one sub-burst
    always_comb begin
        split_cnt_d = split_cnt_q;
        if ((accept_rd | accept_wr_first) & is_split & (split_cnt_q != '1))
            split_cnt_d = split_cnt_q + 32'd1;
    end

    // Statistics register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) split_cnt_q <= '0;
        else          split_cnt_q <= split_cnt_d;
    end

    assign split_count = split_cnt_q;
`else
    assign split_count = '0;
`endif

endmodule

// File: tb/tb_avmm_page_burst_splitter.sv
// Directed bench for avmm_page_burst_splitter (default parameters).
// Expected split_count follows whether AVMM_PAGE_SPLIT_STATS_EN is defined.
module tb_avmm_page_burst_splitter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [47:0]  s_address;
    logic [6:0]   s_burstcount;
    logic [7:0]   s_user;
    logic         s_read, s_write;
    logic [511:0] s_writedata;
    logic [63:0]  s_byteenable;
    logic         s_waitrequest;
    logic [511:0] s_readdata;
    logic         s_readdatavalid, s_writeresponsevalid;
    logic [47:0]  m_address;
    logic [6:0]   m_burstcount;
    logic [7:0]   m_user;
    logic         m_read, m_write;
    logic [511:0] m_writedata;
    logic [63:0]  m_byteenable;
    logic         m_waitrequest;
    logic [511:0] m_readdata;
    logic         m_readdatavalid, m_writeresponsevalid;
    logic [31:0]  split_count;

`ifdef AVMM_PAGE_SPLIT_STATS_EN
    localparam logic [31:0] EXP_SPLITS = 32'd3;
`else
    localparam logic [31:0] EXP_SPLITS = 32'd0;
`endif

    typedef struct {
        logic [47:0]  a;
        logic [6:0]   c;
        logic [7:0]   u;
        logic [511:0] d;
        logic [63:0]  be;
    } cmd_t;

    cmd_t         rdq[$];
    cmd_t         wbq[$];
    logic [511:0] rdataq[$];
    int           tests = 0;
    int           fails = 0;

    avmm_page_burst_splitter dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_user(s_user),
        .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_writeresponsevalid(s_writeresponsevalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_user(m_user),
        .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_writeresponsevalid(m_writeresponsevalid),
        .split_count(split_count)
    );

    always #5 clk = ~clk;

    // Downstream transfers and upstream read returns, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n && !m_waitrequest) begin
            if (m_read)
                rdq.push_back('{m_address, m_burstcount, m_user, m_writedata, m_byteenable});
            if (m_write)
                wbq.push_back('{m_address, m_burstcount, m_user, m_writedata, m_byteenable});
        end
        if (s_readdatavalid) rdataq.push_back(s_readdata);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] bdat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {16{w}};
    endfunction

    task automatic wait_accept(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!s_waitrequest) ok = 1;
            @(posedge clk);
            #1;
        end
        chk(tag, 512'(ok), 512'd1);
    endtask

    task automatic rd(input logic [47:0] a, input logic [6:0] n, input logic [7:0] u);
        s_address = a; s_burstcount = n; s_user = u; s_read = 1'b1;
        wait_accept("rd_accept");
        s_read = 1'b0;
    endtask

    task automatic wr(input logic [47:0] a, input logic [6:0] n, input int nbeats);
        s_address = a; s_burstcount = n; s_user = 8'h77; s_write = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            s_writedata = bdat(b);
            wait_accept("wr_accept");
        end
        s_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        s_address = '0; s_burstcount = '0; s_user = '0;
        s_read = 1'b0; s_write = 1'b0;
        s_writedata = '0; s_byteenable = '1;
        m_waitrequest = 1'b0; m_readdata = '0;
        m_readdatavalid = 1'b0; m_writeresponsevalid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_read", 512'(m_read), 512'd0);
        chk("rst_m_write", 512'(m_write), 512'd0);
        chk("rst_m_address", 512'(m_address), 512'd0);
        chk("rst_m_burstcount", 512'(m_burstcount), 512'd0);
        chk("rst_m_user", 512'(m_user), 512'd0);
        chk("rst_s_wrv", 512'(s_writeresponsevalid), 512'd0);
        chk("rst_split_count", 512'(split_count), 512'd0);
        chk("rst_waitreq", 512'(s_waitrequest), 512'd1);
        reset_n = 1'b1;
        chk("rel_waitreq_hold", 512'(s_waitrequest), 512'd1);
        @(posedge clk);
        #1;
        chk("rel_waitreq_low", 512'(s_waitrequest), 512'd0);

        // Single-page read passes unchanged, one cycle later
        rd(48'h10, 7'd8, 8'h5A);
        chk("r26_m_read", 512'(m_read), 512'd1);
        chk("r26_addr", 512'(m_address), 512'h10);
        chk("r26_cnt", 512'(m_burstcount), 512'd8);
        chk("r26_user", 512'(m_user), 512'h5A);
        @(posedge clk);
        #1;
        chk("r26_one_burst", 512'(m_read), 512'd0);
        chk("r26_split_count", 512'(split_count), 512'd0);
        rdq.delete();

        // Read crossing a page: 4 + 4, data in order
        rd(48'h3C, 7'd8, 8'h33);
        repeat (4) @(posedge clk);
        #1;
        chk("r27_nsub", 512'(rdq.size()), 512'd2);
        if (rdq.size() == 2) begin
            chk("r27_a0", 512'(rdq[0].a), 512'h3C);
            chk("r27_c0", 512'(rdq[0].c), 512'd4);
            chk("r27_a1", 512'(rdq[1].a), 512'h40);
            chk("r27_c1", 512'(rdq[1].c), 512'd4);
            chk("r27_u1", 512'(rdq[1].u), 512'h33);
        end
        for (int k = 0; k < 8; k++) begin
            m_readdatavalid = 1'b1;
            m_readdata = bdat(100 + k);
            @(posedge clk);
            #1;
        end
        m_readdatavalid = 1'b0;
        @(posedge clk);
        #1;
        chk("r27_nbeats", 512'(rdataq.size()), 512'd8);
        for (int k = 0; k < 8 && k < rdataq.size(); k++)
            chk("r27_rdata", rdataq[k], bdat(100 + k));
        rdq.delete();

        // Write 0x7E x66 -> 2 + 64, one merged response after the second
        wr(48'h7E, 7'd66, 66);
        repeat (2) @(posedge clk);
        #1;
        chk("r28_nbeats", 512'(wbq.size()), 512'd66);
        if (wbq.size() == 66) begin
            chk("r28_a0", 512'(wbq[0].a), 512'h7E);
            chk("r28_c0", 512'(wbq[0].c), 512'd2);
            chk("r28_u0", 512'(wbq[0].u), 512'h77);
            chk("r28_be0", 512'(wbq[0].be), {448'd0, 64'hFFFF_FFFF_FFFF_FFFF});
            chk("r28_a2", 512'(wbq[2].a), 512'h80);
            chk("r28_c2", 512'(wbq[2].c), 512'd64);
            for (int b = 0; b < 66; b++)
                chk("r28_wdata", wbq[b].d, bdat(b));
        end
        m_writeresponsevalid = 1'b1;
        @(posedge clk);
        #1;
        m_writeresponsevalid = 1'b0;
        chk("r28_no_early_rsp", 512'(s_writeresponsevalid), 512'd0);
        @(posedge clk);
        #1;
        chk("r28_no_rsp_idle", 512'(s_writeresponsevalid), 512'd0);
        m_writeresponsevalid = 1'b1;
        @(posedge clk);
        #1;
        m_writeresponsevalid = 1'b0;
        chk("r28_merged_rsp", 512'(s_writeresponsevalid), 512'd1);
        @(posedge clk);
        #1;
        chk("r28_rsp_pulse", 512'(s_writeresponsevalid), 512'd0);
        wbq.delete();

        // Read 0x3F x127 with a 5-cycle downstream stall mid-split
        rd(48'h3F, 7'd127, 8'h11);
        chk("r29_first_cnt", 512'(m_burstcount), 512'd1);
        @(posedge clk);
        #1;
        m_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("r29_stall_read", 512'(m_read), 512'd1);
            chk("r29_stall_addr", 512'(m_address), 512'h40);
            chk("r29_stall_cnt", 512'(m_burstcount), 512'd64);
            chk("r29_stall_wreq", 512'(s_waitrequest), 512'd1);
        end
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("r29_nsub", 512'(rdq.size()), 512'd3);
        if (rdq.size() == 3) begin
            chk("r29_a0", 512'(rdq[0].a), 512'h3F);
            chk("r29_c0", 512'(rdq[0].c), 512'd1);
            chk("r29_a1", 512'(rdq[1].a), 512'h40);
            chk("r29_c1", 512'(rdq[1].c), 512'd64);
            chk("r29_a2", 512'(rdq[2].a), 512'h80);
            chk("r29_c2", 512'(rdq[2].c), 512'd62);
        end
        chk("split_count_3", 512'(split_count), 512'(EXP_SPLITS));
        rdq.delete();

        // 16 outstanding writes fill the response FIFO
        for (int w = 0; w < 16; w++) wr(48'(w), 7'd1, 1);
        s_address = 48'h100; s_burstcount = 7'd1;
        s_writedata = bdat(7); s_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("r30_full_stall", 512'(s_waitrequest), 512'd1);
        end
        @(posedge clk);
        #1;
        m_writeresponsevalid = 1'b1;
        @(negedge clk);
        chk("r30_still_full", 512'(s_waitrequest), 512'd1);
        @(posedge clk);
        #1;
        m_writeresponsevalid = 1'b0;
        chk("r30_pop_rsp", 512'(s_writeresponsevalid), 512'd1);
        @(negedge clk);
        chk("r30_unstall", 512'(s_waitrequest), 512'd0);
        @(posedge clk);
        #1;
        s_write = 1'b0;
        chk("r30_17th_write", 512'(m_write), 512'd1);
        chk("r30_17th_addr", 512'(m_address), 512'h100);
        m_writeresponsevalid = 1'b1;
        @(posedge clk);
        #1;
        m_writeresponsevalid = 1'b0;
        chk("r30_second_pop", 512'(s_writeresponsevalid), 512'd1);

        // Reset in the middle of a write split
        wr(48'h200, 7'd4, 2);
        reset_n = 1'b0;
        #1;
        chk("r31_m_write", 512'(m_write), 512'd0);
        chk("r31_m_read", 512'(m_read), 512'd0);
        chk("r31_m_address", 512'(m_address), 512'd0);
        chk("r31_m_burstcount", 512'(m_burstcount), 512'd0);
        chk("r31_m_user", 512'(m_user), 512'd0);
        chk("r31_s_wrv", 512'(s_writeresponsevalid), 512'd0);
        chk("r31_waitreq", 512'(s_waitrequest), 512'd1);
        chk("r31_split_count", 512'(split_count), 512'd0);
        wbq.delete();
        rdq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("r31_rel_hold", 512'(s_waitrequest), 512'd1);
        @(posedge clk);
        #1;
        rd(48'h0, 7'd1, 8'h00);
        chk("r31_rd_read", 512'(m_read), 512'd1);
        chk("r31_rd_addr", 512'(m_address), 512'd0);
        chk("r31_rd_cnt", 512'(m_burstcount), 512'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("r31_no_replay", 512'(wbq.size()), 512'd0);
        chk("r31_one_read", 512'(rdq.size()), 512'd1);
        chk("r31_split_after", 512'(split_count), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
